// File: rtl/hdmi_pkt_pkg.sv
// Shared definitions for the HDMI data-island packet path.
// Holds the packet type encoding, field widths, the scheduler state type and
// a helper that clamps an audio FIFO level to the samples one packet can carry.
package hdmi_pkt_pkg;

    localparam int unsigned PKT_TYPE_W   = 3;
    localparam int unsigned SAMPLE_CNT_W = 3;
    localparam int unsigned AUDIO_LVL_W  = 5;

    localparam logic [PKT_TYPE_W-1:0] PKT_NONE  = 3'd0;
    localparam logic [PKT_TYPE_W-1:0] PKT_ACR   = 3'd1;
    localparam logic [PKT_TYPE_W-1:0] PKT_AUDIO = 3'd2;
    localparam logic [PKT_TYPE_W-1:0] PKT_AVI   = 3'd3;
    localparam logic [PKT_TYPE_W-1:0] PKT_AIF   = 3'd4;

    localparam int unsigned MAX_AUDIO_SAMPLES = 4;

    // Bit positions in the pending-flag vector handed to the arbiter.
    localparam int unsigned PEND_ACR = 0;
    localparam int unsigned PEND_AVI = 1;
    localparam int unsigned PEND_AIF = 2;
    localparam int unsigned PEND_W   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StBusy
    } sched_state_e;

    function automatic logic [SAMPLE_CNT_W-1:0] audio_samples(
        input logic [AUDIO_LVL_W-1:0] level
    );
        logic [SAMPLE_CNT_W-1:0] cnt;
        if (level >= AUDIO_LVL_W'(MAX_AUDIO_SAMPLES)) begin
            cnt = SAMPLE_CNT_W'(MAX_AUDIO_SAMPLES);
        end else begin
            cnt = level[SAMPLE_CNT_W-1:0];
        end
        return cnt;
    endfunction

endpackage

// File: rtl/island_arbiter.sv
// Combinational fixed-priority selector for data-island packets.
// Order: urgent audio > ACR > AVI > AIF > non-urgent audio.
// Ports:
//   pend         in  pending flags (PEND_ACR/PEND_AVI/PEND_AIF bit positions)
//   audio_urgent in  audio FIFO level is at or above the urgency threshold
//   audio_level  in  samples held in the audio FIFO
//   win_type     out winning packet type, PKT_NONE when nothing is requested
//   win_count    out samples to carry when the winner is audio, else 0
module island_arbiter
    import hdmi_pkt_pkg::*;
(
    input  logic [PEND_W-1:0]       pend,
    input  logic                    audio_urgent,
    input  logic [AUDIO_LVL_W-1:0]  audio_level,
    output logic [PKT_TYPE_W-1:0]   win_type,
    output logic [SAMPLE_CNT_W-1:0] win_count
);

    logic audio_req;

    always_comb begin
        audio_req = (audio_level != '0);
        win_type  = PKT_NONE;
        win_count = '0;
        if (audio_req && audio_urgent) begin
            win_type  = PKT_AUDIO;
            win_count = audio_samples(audio_level);
        end else if (pend[PEND_ACR]) begin
            win_type = PKT_ACR;
        end else if (pend[PEND_AVI]) begin
            win_type = PKT_AVI;
        end else if (pend[PEND_AIF]) begin
            win_type = PKT_AIF;
        end else if (audio_req) begin
            win_type  = PKT_AUDIO;
            win_count = audio_samples(audio_level);
        end
    end

endmodule

// File: rtl/island_scheduler.sv
// Data-island packet scheduler for the HDMI front end.
// Opens an arbitration window on each line_end, grants up to MAX_PKTS_PER_LINE
// packets one at a time to the encoder, and aborts a packet the encoder never
// finishes within TIMEOUT_CYCLES.
// Ports:
//   clk, rst          pixel clock; synchronous active-high reset
//   line_end          end-of-line pulse; opens the window, advances ACR counter
//   frame_end         end-of-frame pulse; requests AVI and Audio InfoFrames
//   island_ok         a new island may still start in this blanking
//   audio_level       samples in the external audio FIFO
//   pkt_done          encoder finished the current packet
//   pkt_start         one-cycle request to the encoder
//   pkt_type          granted packet type, held until the next grant
//   sample_count      audio samples carried by the granted packet
//   audio_pop         FIFO pops sample_count samples
//   busy              packet outstanding
//   timeout_err       sticky encoder-timeout flag
module island_scheduler
    import hdmi_pkt_pkg::*;
#(
    parameter int unsigned MAX_PKTS_PER_LINE = 2,
    parameter int unsigned ACR_PERIOD_LINES  = 64,
    parameter int unsigned AUDIO_URGENT      = 3,
    parameter int unsigned TIMEOUT_CYCLES    = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_end,
    input  logic                    frame_end,
    input  logic                    island_ok,
    input  logic [AUDIO_LVL_W-1:0]  audio_level,
    input  logic                    pkt_done,
    output logic                    pkt_start,
    output logic [PKT_TYPE_W-1:0]   pkt_type,
    output logic [SAMPLE_CNT_W-1:0] sample_count,
    output logic                    audio_pop,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned LineW = (ACR_PERIOD_LINES > 2) ? $clog2(ACR_PERIOD_LINES) : 1;
    localparam int unsigned WdW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SlotW = 3;

    sched_state_e state_q, state_d;

    logic [LineW-1:0]        line_cnt_q, line_cnt_d;
    logic [SlotW-1:0]        slots_q, slots_d;
    logic [WdW-1:0]          wd_q, wd_d;
    logic [PEND_W-1:0]       pend_q, pend_d;
    logic                    pkt_start_q, pkt_start_d;
    logic [PKT_TYPE_W-1:0]   pkt_type_q, pkt_type_d;
    logic [SAMPLE_CNT_W-1:0] sample_count_q, sample_count_d;
    logic                    audio_pop_q, audio_pop_d;
    logic                    busy_q, busy_d;
    logic                    timeout_err_q, timeout_err_d;

    logic [PKT_TYPE_W-1:0]   win_type;
    logic [SAMPLE_CNT_W-1:0] win_count;
    logic                    audio_urgent;
    logic                    grant;
    logic                    done_ok;
    logic                    wd_expired;

    assign audio_urgent = (audio_level >= AUDIO_LVL_W'(AUDIO_URGENT));

    island_arbiter u_arbiter (
        .pend         (pend_q),
        .audio_urgent (audio_urgent),
        .audio_level  (audio_level),
        .win_type     (win_type),
        .win_count    (win_count)
    );

    assign grant      = (state_q == StArb) && island_ok &&
                        (slots_q < SlotW'(MAX_PKTS_PER_LINE)) && (win_type != PKT_NONE);
    assign done_ok    = (state_q == StBusy) && pkt_done;
    // Watchdog starts at 0 in the pkt_start cycle, so expiry lands TIMEOUT_CYCLES later.
    assign wd_expired = (state_q == StBusy) && !pkt_done && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            line_cnt_q     <= '0;
            slots_q        <= '0;
            wd_q           <= '0;
            pend_q         <= '0;
            pkt_start_q    <= 1'b0;
            pkt_type_q     <= PKT_NONE;
            sample_count_q <= '0;
            audio_pop_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_cnt_q     <= line_cnt_d;
            slots_q        <= slots_d;
            wd_q           <= wd_d;
            pend_q         <= pend_d;
            pkt_start_q    <= pkt_start_d;
            pkt_type_q     <= pkt_type_d;
            sample_count_q <= sample_count_d;
            audio_pop_q    <= audio_pop_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (line_end) state_d = StArb;
            StArb:  state_d = grant ? StBusy : StIdle;
            StBusy: begin
                if (done_ok) begin
                    state_d = StArb;
                end else if (wd_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values.
    always_comb begin
        line_cnt_d     = line_cnt_q;
        slots_d        = slots_q;
        wd_d           = wd_q;
        pend_d         = pend_q;
        pkt_start_d    = 1'b0;
        pkt_type_d     = pkt_type_q;
        sample_count_d = sample_count_q;
        audio_pop_d    = 1'b0;
        busy_d         = busy_q;
        timeout_err_d  = timeout_err_q;

        // Clears first so that a coincident set below wins.
        if (done_ok) begin
            case (pkt_type_q)
                PKT_ACR: pend_d[PEND_ACR] = 1'b0;
                PKT_AVI: pend_d[PEND_AVI] = 1'b0;
                PKT_AIF: pend_d[PEND_AIF] = 1'b0;
                default: ;
            endcase
        end

        if (line_end) begin
            if (line_cnt_q == LineW'(ACR_PERIOD_LINES - 1)) begin
                line_cnt_d       = '0;
                pend_d[PEND_ACR] = 1'b1;
            end else begin
                line_cnt_d = line_cnt_q + 1'b1;
            end
        end
        if (frame_end) begin
            pend_d[PEND_AVI] = 1'b1;
            pend_d[PEND_AIF] = 1'b1;
        end

        if (state_q == StIdle && line_end) begin
            slots_d = '0;
        end

        if (grant) begin
            slots_d        = slots_q + 1'b1;
            wd_d           = '0;
            pkt_start_d    = 1'b1;
            busy_d         = 1'b1;
            pkt_type_d     = win_type;
            sample_count_d = win_count;
        end

        if (done_ok) begin
            busy_d      = 1'b0;
            audio_pop_d = (pkt_type_q == PKT_AUDIO);
        end else if (wd_expired) begin
            busy_d        = 1'b0;
            timeout_err_d = 1'b1;
        end else if (state_q == StBusy) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        pkt_start    = pkt_start_q;
        pkt_type     = pkt_type_q;
        sample_count = sample_count_q;
        audio_pop    = audio_pop_q;
        busy         = busy_q;
        timeout_err  = timeout_err_q;
    end

endmodule

// File: doc/island_scheduler.md
Name: island_scheduler

Overview:
- Sequences data-island packets for the HDMI front end during horizontal blanking.
- Arbitrates between Audio Clock Regeneration (ACR), audio sample, AVI InfoFrame and Audio InfoFrame requesters.
- Issues one packet request at a time to the packet encoder and enforces a per-line island budget.
- Sits between the timing generator (line_end/frame_end/island_ok) and the packet encoder / audio sample FIFO.

Parameters:
- MAX_PKTS_PER_LINE, 2, maximum packets started per blanking interval (1..7).
- ACR_PERIOD_LINES, 64, ACR packet requested once every N line_end pulses (2..4095).
- AUDIO_URGENT, 3, FIFO level at or above which audio preempts all other requesters.
- TIMEOUT_CYCLES, 1023, maximum cycles from pkt_start to pkt_done before abort.

Ports:
- clk  in  1  pixel clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- line_end  in  1  one-cycle pulse at end of active line.
- frame_end  in  1  one-cycle pulse at end of frame; coincides with a line_end.
- island_ok  in  1  high while a new data island may still start in this blanking.
- audio_level  in  5  samples currently held in the external audio FIFO (0..31).
- pkt_done  in  1  one-cycle pulse from the encoder when the current packet is finished.
- pkt_start  out  1  one-cycle request to the encoder.
- pkt_type  out  3  packet type, valid while busy.
- sample_count  out  3  samples carried (1..4) when pkt_type=AUDIO, else 0.
- audio_pop  out  1  one-cycle pulse: FIFO pops sample_count samples.
- busy  out  1  packet outstanding.
- timeout_err  out  1  sticky; set on encoder timeout.

Behaviour:
- Reset: all outputs 0, pkt_type=NONE, all pending flags clear, line counter 0, state IDLE.
- Pending flags:
  - acr_pend: set on the line_end where line counter = ACR_PERIOD_LINES-1; the counter wraps to 0 there and otherwise increments on every line_end in any state.
  - avi_pend and aif_pend: set on frame_end.
  - A set coinciding with a clear of the same flag: set wins.
- Audio request: audio_level >= 1. Urgent when audio_level >= AUDIO_URGENT.
- Priority, fixed: urgent audio > ACR > AVI > AIF > non-urgent audio.
- State IDLE:
  - line_end -> ARB; slot counter cleared.
  - line_end seen while not in IDLE does not reopen or extend the window.
- State ARB (one cycle):
  - Go to IDLE if island_ok=0, slots=MAX_PKTS_PER_LINE, or nothing is pending.
  - Otherwise: latch the winner into pkt_type, latch sample_count=min(audio_level,4) for audio, assert pkt_start for exactly one cycle, busy=1, increment slots, go to BUSY.
- Timing:
  - line_end high in cycle t -> pkt_start in cycle t+2.
  - pkt_done in cycle d -> ARB in d+1 -> next pkt_start no earlier than d+2.
- State BUSY:
  - On pkt_done: clear the pending flag of the granted type. For AUDIO, pulse audio_pop in the cycle after pkt_done with sample_count held. busy=0, go to ARB.
  - pkt_done outside BUSY is ignored.
  - Watchdog counts from pkt_start. At TIMEOUT_CYCLES without pkt_done: set timeout_err, busy=0, go to IDLE, pending flag retained, no audio_pop.
- pkt_type and sample_count are held until the next grant; both return to 0 only on reset.
- Reset mid-packet discards the outstanding request with no audio_pop. The encoder must treat rst as abort.
- timeout_err clears only on rst.

Decomposition:
- Package hdmi_pkt_pkg holds:
  - Packet type constants: NONE=0, ACR=1, AUDIO=2, AVI=3, AIF=4.
  - Width constant PKT_TYPE_W=3.
  - Max samples per audio packet = 4.
- Sub-module island_arbiter: combinational fixed-priority selector taking pending vector, urgency and audio_level, returning winner type and sample_count. The FSM, counters and watchdog stay in island_scheduler.

Test Plan:
- Reset, then frame_end+line_end with island_ok=1, audio_level=0 -> pkt_start at t+2 with AVI. pkt_done -> AIF two cycles later. Slots exhausted (MAX=2) -> IDLE; ACR is not due.
- 64 line_end pulses, audio_level=0, island_ok=1 -> exactly one ACR pkt_start, on the 64th line's window; none on lines 1..63.
- audio_level=2 with avi_pend set -> AVI granted first. audio_level=3 -> AUDIO granted first with sample_count=3, then audio_pop pulse of count 3 after pkt_done.
- island_ok dropped while BUSY -> current packet completes. Next ARB returns to IDLE with remaining flags retained, and they are served on the next line.
- No pkt_done for 1023 cycles -> timeout_err=1, busy=0, flag retained and regranted on the next line_end.
- rst asserted in BUSY with AUDIO granted -> next cycle all outputs 0 and no audio_pop. A subsequent pkt_done is ignored.
